// File: rtl/mm_result_drain.sv
// mm_result_drain: buffers per-lane systolic results and serialises them lane-by-lane into 32-bit AXI-Stream words.
// Optional statistics counters (stall_cycles, matrices_done) are enabled by defining MM_DRAIN_STATS_EN.
module mm_result_drain #(
    parameter int M          = 16,
    parameter int N1         = 16,
    parameter int D_W_ACC    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N1-1:0]       valid_D,
    input  logic [D_W_ACC-1:0]  data_D [0:N1-1],
    output logic [31:0]         m_axis_mm2s_tdata,
    output logic [3:0]          m_axis_mm2s_tkeep,
    output logic                m_axis_mm2s_tlast,
    output logic                m_axis_mm2s_tvalid,
    input  logic                m_axis_mm2s_tready,
    output logic                overflow
`ifdef MM_DRAIN_STATS_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [15:0]         matrices_done
`endif
);
    localparam int K     = 32 / D_W_ACC;
    localparam int WORDS = M * M / K;
    localparam int WC_W  = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int LW    = N1 > 1 ? $clog2(N1) : 1;
    localparam int SW    = K > 1 ? $clog2(K) : 1;
    localparam logic FILL = 1'b0;
    localparam logic SEND = 1'b1;

    if (D_W_ACC != 8 && D_W_ACC != 16 && D_W_ACC != 32) begin : g_bad_width
        $error("mm_result_drain: D_W_ACC must be 8, 16 or 32");
    end
    if ((M * M) % K != 0) begin : g_bad_words
        $error("mm_result_drain: M*M must be a multiple of 32/D_W_ACC");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mm_result_drain: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [D_W_ACC-1:0] head_w [N1];
    logic [N1-1:0]      ne_w;
    logic [N1-1:0]      full_w;
    logic [LW-1:0]      lane_sel_q, lane_sel_d;
    logic [SW-1:0]      slot_q, slot_d;
    logic [31:0]        pack_q, pack_d;
    logic [31:0]        tdata_q, tdata_d;
    logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
    logic               state_q, state_d;
    logic               overflow_q;
    logic               last_slot, pop, load, hs;

    for (genvar i = 0; i < N1; i++) begin : g_lane
        logic [D_W_ACC-1:0] mem_q [FIFO_DEPTH];
        logic [PW-1:0]      wp_q, rp_q;
        logic [PW:0]        cnt_q;
        logic               wr, rd;
        assign full_w[i]  = cnt_q == (PW+1)'(FIFO_DEPTH);
        assign ne_w[i]    = cnt_q != '0;
        assign head_w[i]  = mem_q[rp_q];
        assign wr         = valid_D[i] && !full_w[i];
        assign rd         = pop && lane_sel_q == LW'(i);
        // Lane FIFO: a push into a full FIFO is dropped; simultaneous push and pop keep occupancy.
        always_ff @(posedge clk) begin
            if (rst) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (wr) begin
                    mem_q[wp_q] <= data_D[i];
                    wp_q        <= wp_q + 1'b1;
                end
                if (rd) rp_q <= rp_q + 1'b1;
                cnt_q <= cnt_q + (PW+1)'(wr) - (PW+1)'(rd);
            end
        end
    end

    assign last_slot = slot_q == SW'(K - 1);
    assign hs        = state_q == SEND && m_axis_mm2s_tready;
    assign pop       = ne_w[lane_sel_q] && !(last_slot && state_q == SEND && !m_axis_mm2s_tready);
    assign load      = pop && last_slot;

    // Serialiser next state: pack one result per pop, hand completed words to the output register.
    always_comb begin
        pack_d     = pack_q;
        slot_d     = slot_q;
        lane_sel_d = lane_sel_q;
        if (pop) begin
            pack_d[int'(slot_q)*D_W_ACC +: D_W_ACC] = head_w[lane_sel_q];
            slot_d     = last_slot ? '0 : slot_q + 1'b1;
            lane_sel_d = lane_sel_q == LW'(N1 - 1) ? '0 : lane_sel_q + 1'b1;
        end
        tdata_d    = load ? pack_d : tdata_q;
        state_d    = load ? SEND : hs ? FILL : state_q;
        word_cnt_d = !hs ? word_cnt_q : word_cnt_q == WC_W'(WORDS - 1) ? '0 : word_cnt_q + 1'b1;
    end

    // Serialiser and output registers; overflow is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q     <= '0;
            slot_q     <= '0;
            lane_sel_q <= '0;
            tdata_q    <= '0;
            state_q    <= FILL;
            word_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            pack_q     <= pack_d;
            slot_q     <= slot_d;
            lane_sel_q <= lane_sel_d;
            tdata_q    <= tdata_d;
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            overflow_q <= overflow_q || |(valid_D & full_w);
        end
    end

    assign m_axis_mm2s_tdata  = tdata_q;
    assign m_axis_mm2s_tkeep  = 4'hF;
    assign m_axis_mm2s_tvalid = state_q == SEND;
    assign m_axis_mm2s_tlast  = state_q == SEND && word_cnt_q == WC_W'(WORDS - 1);
    assign overflow           = overflow_q;

`ifdef MM_DRAIN_STATS_EN
    logic [31:0] stall_q;
    logic [15:0] mdone_q;
    // Stall cycles saturate; completed matrices wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            mdone_q <= '0;
        end else begin
            if (state_q == SEND && !m_axis_mm2s_tready && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 1'b1;
            if (hs && m_axis_mm2s_tlast) mdone_q <= mdone_q + 1'b1;
        end
    end
    assign stall_cycles  = stall_q;
    assign matrices_done = mdone_q;
`endif
endmodule
